apb_slave: RTL and testbench

APB_SLAVE -- requirements
Module: apb_slave

---
 rtl/apb_pkg.sv | 15 +
 rtl/apb_regfile.sv | 41 ++++
 rtl/apb_slave.sv | 112 +++++++++++
 tb/tb_apb_slave.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared definitions for the APB completer: bus widths, FSM encoding and the ID word.
package apb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  localparam logic [DATA_W-1:0] ID_VALUE = 32'hA5B0_0001;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_e;

endpackage

// File: rtl/apb_regfile.sv
// Register file: one write port, one asynchronous read port. Word 0 is the fixed ID.
module apb_regfile
  import apb_pkg::*;
#(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned IDX_W    = $clog2(NUM_REGS)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [IDX_W-1:0]  i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] w_regs [NUM_REGS];

  // Word 0 has no storage; it always reads back the ID constant.
  assign w_regs[0] = ID_VALUE;

  genvar gi;
  generate
    for (gi = 1; gi < NUM_REGS; gi++) begin : g_reg
      logic [DATA_W-1:0] r_word;

      always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
          r_word <= '0;
        end else if (i_we && (i_waddr == IDX_W'(gi))) begin
          r_word <= i_wdata;
        end
      end

      assign w_regs[gi] = r_word;
    end
  endgenerate

  assign o_rdata = w_regs[i_raddr];

endmodule

// File: rtl/apb_slave.sv
// APB completer: IDLE/SETUP/ACCESS FSM with programmable wait states in front of a
// small register file. All outputs are decoded from registered state only.
module apb_slave
  import apb_pkg::*;
#(
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr
);

  localparam int unsigned       IDX_W      = $clog2(NUM_REGS);
  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(NUM_REGS * 4);
  localparam logic [3:0]        WAIT_LAST  = 4'(WAIT_CYCLES);

  apb_state_e        r_state;
  apb_state_e        w_state_next;
  logic [3:0]        r_wait;
  logic [3:0]        w_wait_next;
  logic [ADDR_W-1:0] r_addr;
  logic              r_write;
  logic [DATA_W-1:0] r_wdata;

  logic              w_ready;
  logic [IDX_W-1:0]  w_idx;
  logic              w_out_of_range;
  logic              w_id_write;
  logic              w_err;
  logic              w_we;
  logic [DATA_W-1:0] w_rdata;

  always_ff @(posedge pclk) begin
    if (!preset) begin
      r_state <= IDLE;
      r_wait  <= '0;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_next;
      r_wait  <= w_wait_next;
      if (r_state == SETUP) begin
        r_addr  <= paddr;
        r_write <= pwrite;
        r_wdata <= pwdata;
      end
    end
  end

  assign w_ready = (r_state == ACCESS) && (r_wait == WAIT_LAST);

  always_comb begin
    w_state_next = r_state;
    w_wait_next  = '0;
    case (r_state)
      IDLE: begin
        if (psel && !penable) begin
          w_state_next = SETUP;
        end
      end
      SETUP: begin
        w_state_next = ACCESS;
      end
      ACCESS: begin
        if (w_ready) begin
          w_state_next = (psel && !penable) ? SETUP : IDLE;
        end else if (!psel || !penable) begin
          // Requester withdrew before completion: drop the transfer.
          w_state_next = IDLE;
        end else begin
          w_wait_next = r_wait + 4'd1;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign w_idx          = r_addr[IDX_W+1:2];
  assign w_out_of_range = (r_addr >= ADDR_LIMIT);
  assign w_id_write     = r_write && (w_idx == '0);
  assign w_err          = w_out_of_range || w_id_write;
  assign w_we           = w_ready && r_write && !w_err;

  apb_regfile #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_regfile (
    .i_clk   (pclk),
    .i_rst_n (preset),
    .i_we    (w_we),
    .i_waddr (w_idx),
    .i_wdata (r_wdata),
    .i_raddr (w_idx),
    .o_rdata (w_rdata)
  );

  assign pready  = w_ready;
  assign pslverr = w_ready && w_err;
  assign prdata  = (w_ready && !r_write && !w_err) ? w_rdata : '0;

endmodule

// File: tb/tb_apb_slave.sv
// Directed bench for apb_slave: three instances (WAIT_CYCLES 1, 0, 3) checked every
// cycle against a transfer-level model of registers and expected completion cycle.
module tb_apb_slave;
  import apb_pkg::*;

  localparam int ND    = 3;
  localparam int NREGS = 16;

  logic        clk = 1'b0;
  logic        rstn;
  logic        psel   [ND];
  logic        pen    [ND];
  logic        pwr    [ND];
  logic [31:0] paddr  [ND];
  logic [31:0] pwdata [ND];
  logic [31:0] prdata [ND];
  logic        prdy   [ND];
  logic        perr   [ND];

  bit          exp_rdy   [ND];
  bit          exp_err   [ND];
  logic [31:0] exp_rdata [ND];
  logic [31:0] mdl [ND][NREGS];

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  logic [31:0] g_rd;
  logic        g_err;

  always #5 clk = ~clk;

  apb_slave #(.NUM_REGS(NREGS), .WAIT_CYCLES(1)) u_w1 (
    .pclk(clk), .preset(rstn), .psel(psel[0]), .penable(pen[0]), .pwrite(pwr[0]),
    .paddr(paddr[0]), .pwdata(pwdata[0]), .prdata(prdata[0]), .pready(prdy[0]), .pslverr(perr[0]));
  apb_slave #(.NUM_REGS(NREGS), .WAIT_CYCLES(0)) u_w0 (
    .pclk(clk), .preset(rstn), .psel(psel[1]), .penable(pen[1]), .pwrite(pwr[1]),
    .paddr(paddr[1]), .pwdata(pwdata[1]), .prdata(prdata[1]), .pready(prdy[1]), .pslverr(perr[1]));
  apb_slave #(.NUM_REGS(NREGS), .WAIT_CYCLES(3)) u_w3 (
    .pclk(clk), .preset(rstn), .psel(psel[2]), .penable(pen[2]), .pwrite(pwr[2]),
    .paddr(paddr[2]), .pwdata(pwdata[2]), .prdata(prdata[2]), .pready(prdy[2]), .pslverr(perr[2]));

  function automatic int wait_of(input int d);
    case (d)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < ND; d++) begin
        checks++;
        if (prdy[d] !== exp_rdy[d]) begin
          failures++;
          $display("FAIL pready dut%0d t=%0t got=%b exp=%b", d, $time, prdy[d], exp_rdy[d]);
        end
        checks++;
        if (perr[d] !== exp_err[d]) begin
          failures++;
          $display("FAIL pslverr dut%0d t=%0t got=%b exp=%b", d, $time, perr[d], exp_err[d]);
        end
        checks++;
        if (prdata[d] !== exp_rdata[d]) begin
          failures++;
          $display("FAIL prdata dut%0d t=%0t got=%h exp=%h", d, $time, prdata[d], exp_rdata[d]);
        end
      end
    end
  end

  // Advance one cycle; every instance is expected quiet unless a transfer says otherwise.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      exp_rdy[d]   = 1'b0;
      exp_err[d]   = 1'b0;
      exp_rdata[d] = 32'h0;
    end
  endtask

  task automatic clear_models();
    for (int d = 0; d < ND; d++)
      for (int i = 0; i < NREGS; i++)
        mdl[d][i] = 32'h0;
  endtask

  task automatic pin(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, expv);
    end
  endtask

  // chain=1 issues the setup phase in the current cycle (the previous pready cycle).
  // abort_k >= 0 withdraws psel (kind 1) or penable (kind 2) in that ACCESS cycle.
  task automatic xfer(input int d, input logic [31:0] addr, input bit wr,
                      input logic [31:0] wdata, input int abort_k, input int abort_kind,
                      input bit chain, output logic [31:0] got_rdata, output logic got_err);
    int          w;
    int          idx;
    bit          err;
    logic [31:0] rd;
    w   = wait_of(d);
    idx = int'(addr[5:2]);
    err = (addr >= 32'(NREGS * 4)) || (wr && idx == 0);
    rd  = (wr || err) ? 32'h0 : ((idx == 0) ? ID_VALUE : mdl[d][idx]);
    got_rdata = 'x;
    got_err   = 1'bx;
    if (!chain) tick();
    psel[d] = 1'b1; pen[d] = 1'b0; paddr[d] = addr; pwr[d] = wr; pwdata[d] = wdata;
    tick();
    pen[d] = 1'b1;
    for (int k = 0; k <= w; k++) begin
      tick();
      if (k == abort_k) begin
        if (abort_kind == 1) psel[d] = 1'b0;
        else                 pen[d]  = 1'b0;
        tick();
        psel[d] = 1'b0; pen[d] = 1'b0;
        $display("xfer dut%0d %s addr=%h data=%h aborted at access cycle %0d",
                 d, wr ? "WR" : "RD", addr, wdata, k);
        return;
      end
      if (k == w) begin
        exp_rdy[d]   = 1'b1;
        exp_err[d]   = err;
        exp_rdata[d] = rd;
        @(negedge clk);
        got_rdata = prdata[d];
        got_err   = perr[d];
      end
    end
    if (wr && !err) mdl[d][idx] = wdata;
    $display("xfer dut%0d %s addr=%h wdata=%h rdata=%h err=%b",
             d, wr ? "WR" : "RD", addr, wdata, got_rdata, got_err);
  endtask

  task automatic go_idle(input int d);
    tick();
    psel[d] = 1'b0; pen[d] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    for (int d = 0; d < ND; d++) begin
      psel[d] = 1'b0; pen[d] = 1'b0; pwr[d] = 1'b0; paddr[d] = '0; pwdata[d] = '0;
      exp_rdy[d] = 1'b0; exp_err[d] = 1'b0; exp_rdata[d] = '0;
    end
    clear_models();
    tick();
    chk_en = 1'b1;
    tick();
    rstn = 1'b1;

    // First transfer is issued in the release cycle itself.
    xfer(0, 32'h04, 1, 32'hDEAD_BEEF, -1, 0, 1, g_rd, g_err);
    pin("wr04_err", {31'b0, g_err}, 32'h0);
    xfer(0, 32'h04, 0, 32'h0, -1, 0, 0, g_rd, g_err);
    pin("rd04_data", g_rd, 32'hDEAD_BEEF);
    pin("rd04_err", {31'b0, g_err}, 32'h0);
    xfer(0, 32'h00, 0, 32'h0, -1, 0, 0, g_rd, g_err);
    pin("rd_id", g_rd, 32'hA5B0_0001);
    xfer(0, 32'h00, 1, 32'h1234, -1, 0, 0, g_rd, g_err);
    pin("wr_id_err", {31'b0, g_err}, 32'h1);
    xfer(0, 32'h00, 0, 32'h0, -1, 0, 0, g_rd, g_err);
    pin("rd_id_again", g_rd, 32'hA5B0_0001);
    xfer(0, 32'h40, 1, 32'h55, -1, 0, 0, g_rd, g_err);
    pin("wr_oor_err", {31'b0, g_err}, 32'h1);
    xfer(0, 32'h40, 0, 32'h0, -1, 0, 0, g_rd, g_err);
    pin("rd_oor_data", g_rd, 32'h0);
    xfer(0, 32'h07, 0, 32'h0, -1, 0, 0, g_rd, g_err);
    pin("rd07_unaligned", g_rd, 32'hDEAD_BEEF);
    xfer(0, 32'h3C, 1, 32'h0F0F_1234, -1, 0, 0, g_rd, g_err);
    xfer(0, 32'h3C, 0, 32'h0, -1, 0, 1, g_rd, g_err);
    pin("rd3c_top_word", g_rd, 32'h0F0F_1234);
    go_idle(0);

    // Zero wait states, fully chained.
    xfer(1, 32'h08, 1, 32'h1111_2222, -1, 0, 0, g_rd, g_err);
    xfer(1, 32'h0C, 1, 32'h3333_4444, -1, 0, 1, g_rd, g_err);
    xfer(1, 32'h08, 0, 32'h0, -1, 0, 1, g_rd, g_err);
    pin("b2b_rd08", g_rd, 32'h1111_2222);
    xfer(1, 32'h0C, 0, 32'h0, -1, 0, 1, g_rd, g_err);
    pin("b2b_rd0c", g_rd, 32'h3333_4444);
    go_idle(1);

    // Three wait states with aborted transfers.
    xfer(2, 32'h10, 1, 32'h77, 0, 1, 0, g_rd, g_err);
    xfer(2, 32'h10, 0, 32'h0, -1, 0, 0, g_rd, g_err);
    pin("abort_psel_rd10", g_rd, 32'h0);
    xfer(2, 32'h10, 1, 32'h99, 2, 2, 0, g_rd, g_err);
    xfer(2, 32'h10, 0, 32'h0, -1, 0, 0, g_rd, g_err);
    pin("abort_pen_rd10", g_rd, 32'h0);
    xfer(2, 32'h10, 1, 32'h0000_ABCD, -1, 0, 0, g_rd, g_err);
    xfer(2, 32'h10, 0, 32'h0, -1, 0, 0, g_rd, g_err);
    pin("full_rd10", g_rd, 32'h0000_ABCD);
    go_idle(2);

    // Reset in the middle of an ACCESS phase on the WAIT_CYCLES=1 instance.
    tick();
    psel[0] = 1'b1; pen[0] = 1'b0; paddr[0] = 32'h14; pwr[0] = 1'b1; pwdata[0] = 32'hCAFE_F00D;
    tick();
    pen[0] = 1'b1;
    tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    psel[0] = 1'b0; pen[0] = 1'b0;
    clear_models();
    $display("xfer dut0 WR addr=00000014 wdata=cafef00d reset during access");
    xfer(0, 32'h14, 0, 32'h0, -1, 0, 0, g_rd, g_err);
    pin("rst_rd14", g_rd, 32'h0);
    xfer(0, 32'h04, 0, 32'h0, -1, 0, 0, g_rd, g_err);
    pin("rst_rd04_cleared", g_rd, 32'h0);
    go_idle(0);
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
